// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, redirect
// priority levels and the sequential PC increment.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } pc_state_e;

  // Numeric order is the priority order, so a plain compare picks the winner.
  typedef enum logic [1:0] {
    PRIO_NONE   = 2'd0,
    PRIO_BRANCH = 2'd1,
    PRIO_JUMP   = 2'd2,
    PRIO_EXC    = 2'd3
  } redir_prio_e;

  localparam int unsigned PC_INCR = 4;

  function automatic redir_prio_e prioOf(input logic exc, input logic jmp, input logic br);
    redir_prio_e p;
    if (exc)      p = PRIO_EXC;
    else if (jmp) p = PRIO_JUMP;
    else if (br)  p = PRIO_BRANCH;
    else          p = PRIO_NONE;
    return p;
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Picks the highest-priority redirect among this cycle's requests and the
// pending one, and holds it until the sequencer consumes it.
module pc_redirect_sel
  import mips_pkg::*;
#(
  parameter int unsigned     SIZE    = 32,
  parameter logic [SIZE-1:0] EXC_VEC = SIZE'(32'h0000_0080)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_exception,
  input  logic            i_jump,
  input  logic [SIZE-1:0] i_jump_target,
  input  logic            i_branch_taken,
  input  logic [SIZE-1:0] i_branch_target,
  input  logic            i_clear,
  output logic            o_valid,
  output logic [SIZE-1:0] o_target
);

  redir_prio_e     r_pend_prio;
  logic [SIZE-1:0] r_pend_target;
  redir_prio_e     w_new_prio;
  redir_prio_e     w_sel_prio;
  logic [SIZE-1:0] w_new_target;
  logic [SIZE-1:0] w_sel_target;

  // A new request only displaces the pending one when it is at least as urgent.
  always_comb begin
    w_new_prio   = prioOf(i_exception, i_jump, i_branch_taken);
    w_new_target = i_exception ? EXC_VEC : (i_jump ? i_jump_target : i_branch_target);
    w_sel_prio   = r_pend_prio;
    w_sel_target = r_pend_target;
    if ((w_new_prio != PRIO_NONE) && (w_new_prio >= r_pend_prio)) begin
      w_sel_prio   = w_new_prio;
      w_sel_target = w_new_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_prio   <= PRIO_NONE;
      r_pend_target <= '0;
    end else if (i_clear) begin
      r_pend_prio   <= PRIO_NONE;
      r_pend_target <= '0;
    end else begin
      r_pend_prio   <= w_sel_prio;
      r_pend_target <= w_sel_target;
    end
  end

  assign o_valid  = (w_sel_prio != PRIO_NONE);
  assign o_target = w_sel_target;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: issues one request at a time, delivers the
// fetched PC, and applies exception/jump/branch redirects.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned     SIZE      = 32,
  parameter logic [SIZE-1:0] RESET_VEC = SIZE'(32'h0000_0000),
  parameter logic [SIZE-1:0] EXC_VEC   = SIZE'(32'h0000_0080)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            exception,
  input  logic            jump,
  input  logic [SIZE-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [SIZE-1:0] branch_target,
  output logic            imem_req,
  output logic [SIZE-1:0] imem_addr,
  input  logic            imem_ready,
  output logic [SIZE-1:0] pc_out,
  output logic            pc_valid,
  output logic [SIZE-1:0] epc
);

  pc_state_e       r_state;
  logic [SIZE-1:0] r_fetch_pc;
  logic            r_imem_req;
  logic [SIZE-1:0] r_imem_addr;
  logic            r_pc_valid;
  logic [SIZE-1:0] r_pc_out;
  logic [SIZE-1:0] r_epc;
  logic            w_redir_valid;
  logic [SIZE-1:0] w_redir_target;
  logic            w_take;

  // In WAIT the redirect stays pending until the memory returns, then squashes it.
  assign w_take = w_redir_valid &&
                  ((r_state == ST_ISSUE) || (r_state == ST_HOLD) ||
                   ((r_state == ST_WAIT) && imem_ready));

  pc_redirect_sel #(
    .SIZE    (SIZE),
    .EXC_VEC (EXC_VEC)
  ) u_redirect_sel (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_exception     (exception),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_clear         (w_take),
    .o_valid         (w_redir_valid),
    .o_target        (w_redir_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_fetch_pc  <= RESET_VEC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_VEC;
      r_pc_valid  <= 1'b0;
      r_pc_out    <= '0;
      r_epc       <= '0;
    end else begin
      r_pc_valid <= 1'b0;
      if (exception) r_epc <= r_fetch_pc;
      case (r_state)
        ST_BOOT: begin
          r_fetch_pc <= RESET_VEC;
          r_state    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (w_take) begin
            r_fetch_pc <= w_redir_target;
          end else if (stall) begin
            r_state <= ST_HOLD;
          end else begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_pc;
            r_state     <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (w_take) r_fetch_pc <= w_redir_target;
          if (!stall) r_state <= ST_ISSUE;
        end
        ST_WAIT: begin
          if (imem_ready) begin
            r_imem_req <= 1'b0;
            r_state    <= ST_ISSUE;
            if (w_take) begin
              r_fetch_pc <= w_redir_target;
            end else begin
              r_pc_valid <= 1'b1;
              r_pc_out   <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + SIZE'(PC_INCR);
            end
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign pc_valid  = r_pc_valid;
  assign pc_out    = r_pc_out;
  assign epc       = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a one-wait-cycle memory, redirects in
// each state, stall, PC wrap and reset during an outstanding fetch.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        exception;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] epc;

  int testsRun  = 0;
  int failCount = 0;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .exception     (exception),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .pc_out        (pc_out),
    .pc_valid      (pc_valid),
    .epc           (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic exc, input logic jmp, input logic [31:0] jTgt,
                               input logic br, input logic [31:0] bTgt);
    exception     = exc;
    jump          = jmp;
    jump_target   = jTgt;
    branch_taken  = br;
    branch_target = bTgt;
  endtask

  // Bounded wait for the next request, then check its address.
  task automatic waitReq(input string tag, input logic [31:0] expAddr);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    checkOutput({tag, "_addr"}, imem_addr, expAddr);
  endtask

  // First WAIT cycle with imem_ready low; request must stay stable.
  task automatic holdWait(input string tag, input logic [31:0] expAddr);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput({tag, "_hold_req"}, {31'b0, imem_req}, 32'd1);
    checkOutput({tag, "_hold_addr"}, imem_addr, expAddr);
  endtask

  // Memory completes; check delivery (or squash) and the single-cycle strobe.
  task automatic completeReq(input string tag, input logic expValid, input logic [31:0] expPc);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput({tag, "_valid"}, {31'b0, pc_valid}, {31'b0, expValid});
    if (expValid) checkOutput({tag, "_pc_out"}, pc_out, expPc);
    checkOutput({tag, "_req_drop"}, {31'b0, imem_req}, 32'd0);
    tick();
    checkOutput({tag, "_pulse_end"}, {31'b0, pc_valid}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) tick();
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", {31'b0, pc_valid}, 32'd0);
    checkOutput("rst_pc_out", pc_out, 32'h0);
    checkOutput("rst_epc", epc, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch 0x0, 0x4, 0x8
    waitReq("seq0", 32'h0);
    holdWait("seq0", 32'h0);
    completeReq("seq0", 1'b1, 32'h0);
    waitReq("seq4", 32'h4);
    holdWait("seq4", 32'h4);
    completeReq("seq4", 1'b1, 32'h4);

    // Jump during WAIT of 0x8 squashes it
    waitReq("seq8", 32'h8);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    holdWait("jmp8", 32'h8);
    completeReq("jmp8", 1'b0, 32'h0);
    waitReq("j100", 32'h100);
    holdWait("j100", 32'h100);
    completeReq("j100", 1'b1, 32'h100);

    // Move to 0x10 for the exception case
    waitReq("s104", 32'h104);
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    holdWait("s104", 32'h104);
    completeReq("s104", 1'b0, 32'h0);

    // Exception + branch together, then a later branch must not override
    waitReq("x10", 32'h10);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
    holdWait("x10", 32'h10);
    checkOutput("x10_epc", epc, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    completeReq("x10", 1'b0, 32'h0);
    waitReq("x80", 32'h80);
    holdWait("x80", 32'h80);
    completeReq("x80", 1'b1, 32'h80);

    // Stall in WAIT still delivers; then three stalled cycles with no request
    waitReq("s84", 32'h84);
    holdWait("s84", 32'h84);
    stall = 1'b1;
    completeReq("s84", 1'b1, 32'h84);
    tick();
    checkOutput("stall_req1", {31'b0, imem_req}, 32'd0);
    tick();
    checkOutput("stall_req2", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    checkOutput("stall_req3", {31'b0, imem_req}, 32'd0);
    waitReq("s88", 32'h88);

    // Wrap from the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    holdWait("s88", 32'h88);
    completeReq("s88", 1'b0, 32'h0);
    waitReq("top", 32'hFFFF_FFFC);
    holdWait("top", 32'hFFFF_FFFC);
    completeReq("top", 1'b1, 32'hFFFF_FFFC);
    waitReq("wrap", 32'h0);

    // Branch while in HOLD takes effect immediately
    holdWait("wrap", 32'h0);
    stall = 1'b1;
    completeReq("wrap", 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    stall = 1'b0;
    waitReq("b200", 32'h200);

    // Reset asserted mid-WAIT drops the request at once
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("arst_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("arst_valid", {31'b0, pc_valid}, 32'd0);
    end
    imem_ready = 1'b0;
    rst_n = 1'b1;
    waitReq("restart", 32'h0);
    checkOutput("restart_epc", epc, 32'h0);
    holdWait("restart", 32'h0);
    completeReq("restart", 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have parameter SIZE, default 32, giving the address width.
REQ-002 The module SHALL have parameter RESET_VEC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The module SHALL have parameter EXC_VEC, default 32'h0000_0080, giving the exception handler address.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 stall  input  1  pipeline hold; no new fetch is issued while high.
REQ-007 exception  input  1  one-cycle pulse; redirect to EXC_VEC.
REQ-008 jump, jump_target  input  1, SIZE  unconditional redirect and its target.
REQ-009 branch_taken, branch_target  input  1, SIZE  taken-branch redirect and its target.
REQ-010 imem_req, imem_addr  output  1, SIZE  instruction-memory request and its address.
REQ-011 imem_ready  input  1  memory completes the outstanding request this cycle.
REQ-012 pc_out, pc_valid  output  SIZE, 1  address of the delivered instruction and its one-cycle valid strobe.
REQ-013 epc  output  SIZE  address of the instruction in flight when the last exception was taken.

Function
REQ-014 The FSM SHALL have states BOOT, ISSUE, WAIT and HOLD.
REQ-015 BOOT SHALL last exactly one cycle after reset release and go to ISSUE with fetch_pc = RESET_VEC.
REQ-016 In ISSUE with stall low, the FSM SHALL drive imem_req=1 and imem_addr=fetch_pc, then go to WAIT.
REQ-017 In ISSUE with stall high, the FSM SHALL go to HOLD with imem_req=0.
REQ-018 HOLD SHALL return to ISSUE on the first cycle stall is low; fetch_pc is unchanged.
REQ-019 In WAIT, imem_req and imem_addr SHALL stay stable until imem_ready is high; only one request is outstanding at a time.
REQ-020 On imem_ready with no redirect pending, the block SHALL pulse pc_valid=1 with pc_out=fetch_pc for one cycle and set fetch_pc to fetch_pc+4, wrapping modulo 2^SIZE.
REQ-021 Redirect priority SHALL be exception > jump > branch_taken > sequential.
REQ-022 A redirect seen in any state SHALL be latched as a pending target; a higher-priority redirect overwrites a lower one, and a lower-priority redirect never overwrites a pending higher one.
REQ-023 A redirect in ISSUE or HOLD SHALL take effect at once: fetch_pc becomes the target and no pc_valid is produced for the old address.
REQ-024 A redirect in WAIT SHALL NOT abort the request; on imem_ready, pc_valid stays 0 (squash), fetch_pc becomes the pending target, and the pending flag clears.
REQ-025 A redirect in the same cycle as imem_ready SHALL squash that returning instruction.
REQ-026 On exception, epc SHALL capture the current fetch_pc in that cycle.
REQ-027 Stall SHALL NOT suppress pc_valid for a request already in WAIT; stall only blocks new issue.
REQ-028 Targets SHALL be used unmodified; alignment is the requester's responsibility.

Reset
REQ-029 While rst_n is low: state=BOOT, fetch_pc=RESET_VEC, imem_req=0, imem_addr=RESET_VEC, pc_valid=0, pc_out=0, epc=0, pending redirect cleared.
REQ-030 rst_n falling mid-WAIT SHALL drop the outstanding request immediately, with no pc_valid afterwards.

Structure
REQ-031 The state encoding, the redirect-priority encoding and the increment constant 4 SHALL be in shared package mips_pkg.
REQ-032 Redirect priority selection and pending-target latch SHALL be one sub-module, pc_redirect_sel.
REQ-033 fetch_pc SHALL be the only program-counter register; no separate PC instance.

Verification
REQ-034 Reset then imem_ready after 1 wait cycle each: pc_out sequence 0x0, 0x4, 0x8, each with one pc_valid pulse.
REQ-035 jump=1, target 0x100, during WAIT of 0x8: 0x8 is squashed, next pc_valid has pc_out=0x100.
REQ-036 exception and branch_taken (0x40) in the same cycle at fetch_pc 0x10: next fetch 0x80, epc=0x10.
REQ-037 stall high 3 cycles in ISSUE: imem_req=0 throughout, then fetch of the unchanged fetch_pc.
REQ-038 Sequential fetch from 0xFFFF_FFFC: next imem_addr=0x0000_0000.
REQ-039 rst_n low while in WAIT: imem_req=0 asynchronously, pc_valid never pulses, restart at RESET_VEC.
